rr_dispatcher: RTL
==================

Name: rr_dispatcher

Overview:
- 1-to-N round-robin stream dispatcher; the counterpart of the N-to-1 round-robin arbiter.
- Takes a single valid/ready input stream and hands each accepted word to exactly one of WIDTH output channels.
- Channel order is strict rotation over the currently enabled channels, continuing after the last channel served.
- Has a one-entry holding register, so an output word is never retracted once presented.

Parameters:
- WIDTH, 4, number of output channels; must be ≥ 2, power of two not required.
- DATA_W, 8, payload width in bits.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous reset, active-low.
- i_en  input  WIDTH  per-channel enable mask, sampled only when a word is loaded.
- i_valid  input  1  upstream word valid.
- i_data  input  DATA_W  upstream payload.
- o_ready  output  1  dispatcher can accept a word this cycle.
- o_valid  output  WIDTH  one-hot per-channel valid; all zero when empty.
- o_data  output  DATA_W  payload, shared by all channels; qualified by o_valid.
- i_ready  input  WIDTH  per-channel downstream ready.
- o_idx  output  $clog2(WIDTH)  index of the channel holding the current word.
- o_busy  output  1  holding register occupied.

Behaviour:
- State: hold_valid, hold_data, hold_idx (target), last_idx (rotation pointer). Two states:
  - EMPTY when hold_valid=0.
  - FULL when hold_valid=1.
- Reset (async assert, sync release) drives these values:
  - hold_valid=0, hold_data=0, hold_idx=0, last_idx=WIDTH-1.
  - Outputs: o_valid=0, o_data=0, o_idx=0, o_busy=0, o_ready=0 while i_rst_n low.
- Outputs while FULL:
  - o_valid = one-hot(hold_idx).
  - o_data = hold_data, o_idx = hold_idx, o_busy = 1.
- Outputs while EMPTY:
  - o_valid = 0, o_busy = 0.
  - o_data and o_idx hold their last values.
- out_fire = hold_valid & i_ready[hold_idx]. i_ready on non-target channels is ignored.
- o_ready = (~hold_valid | out_fire) & (|i_en). o_ready depends combinationally on i_ready and i_en, but never on i_valid.
- in_fire = i_valid & o_ready.
- Target selection, combinational:
  - Search i_en cyclically from index last_idx+1 (mod WIDTH) upward, wrapping to 0.
  - The first set bit is next_idx.
  - last_idx itself is eligible only as the final candidate; it is chosen when it is the only enabled channel.
- On in_fire, registered:
  - hold_valid=1, hold_data=i_data, hold_idx=next_idx, last_idx=next_idx.
  - Latency from input accept to o_valid is 1 cycle.
- On out_fire & ~in_fire: hold_valid=0.
- On out_fire & in_fire in the same cycle:
  - The new word replaces the old one; hold_valid stays 1.
  - Sustained throughput is one word per cycle.
- i_en = 0 gives o_ready=0; a word already held is still delivered.
- Changing i_en while FULL does not move hold_idx. The target is locked at load, even if the channel becomes disabled.
- o_valid[k], o_data and o_idx stay stable while FULL and unfired. Valid is never dropped without a handshake.
- Boundary cases:
  - Rotation pointer wraps from WIDTH-1 to 0.
  - Non-power-of-two WIDTH: candidate indices ≥ WIDTH are never produced.
  - Index arithmetic uses $clog2(WIDTH)+1 bits before the modulo.
- Reset asserted mid-transfer discards the held word with no partial handshake. After release, dispatch restarts at the lowest enabled channel.
- Implementation: a generic cyclic first-set search, or a masked priority encoder instance with pivot = last_idx+1 (LSB-first, wrap preferred).

Test Plan:
- Reset, i_en=4'b1111, i_valid=1 continuously, all i_ready=1, data 0xA0..0xA7 → o_valid one-hot cycles 0,1,2,3,0,1,2,3 starting 1 cycle after first accept; o_data matches; one word per cycle.
- i_en=4'b1010, four words → targets 1,3,1,3; o_valid[0] and o_valid[2] are never asserted.
- Word 0x55 to channel 2, i_ready[2]=0 for 5 cycles while i_ready[0,1,3]=1 → o_valid=4'b0100 and o_data=0x55 stable; o_ready=0; fires on cycle i_ready[2] rises; next word goes to channel 3.
- i_en=0 with i_valid=1 → o_ready=0 and o_valid=0 throughout; set i_en=4'b0001 → accepts, target 0, and target stays 0 on every subsequent word.
- Word held for channel 1; i_en changes 4'b1111→4'b1101 before fire → still delivered on channel 1; next target 2.
- Assert i_rst_n low while FULL for channel 3 → o_valid=0 and o_busy=0 immediately; after release with i_en=4'b1111 the first word goes to channel 0.

Source files
------------

// File: rtl/rr_dispatcher_if.sv
// Handshake bundle between one upstream source, the round-robin dispatcher and its WIDTH sinks.
// The slave modport is the dispatcher's view; master is the surrounding environment's view.
interface rr_dispatcher_if #(
   parameter int WIDTH  = 4,
   parameter int DATA_W = 8
);
   localparam int IDX_W = $clog2(WIDTH);

   logic [WIDTH-1:0]  i_en;
   logic              i_valid;
   logic [DATA_W-1:0] i_data;
   logic              o_ready;
   logic [WIDTH-1:0]  o_valid;
   logic [DATA_W-1:0] o_data;
   logic [WIDTH-1:0]  i_ready;
   logic [IDX_W-1:0]  o_idx;
   logic              o_busy;

   modport slave (
      input  i_en, i_valid, i_data, i_ready,
      output o_ready, o_valid, o_data, o_idx, o_busy
   );

   modport master (
      output i_en, i_valid, i_data, i_ready,
      input  o_ready, o_valid, o_data, o_idx, o_busy
   );
endinterface

// File: rtl/rr_dispatcher.sv
// 1-to-N round-robin stream dispatcher with a one-entry holding register: each accepted word
// goes to the next enabled channel after the last one served and is never retracted once shown.
module rr_dispatcher #(
   parameter int WIDTH  = 4,
   parameter int DATA_W = 8
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   rr_dispatcher_if.slave bus
);
   localparam int IDX_W = $clog2(WIDTH);
   localparam int CW    = IDX_W + 1;

   localparam logic [0:0]    ST_EMPTY = 1'b0;
   localparam logic [0:0]    ST_FULL  = 1'b1;
   localparam logic [CW-1:0] WIDTH_C  = CW'(WIDTH);

   logic [0:0]        state_q, state_d;
   logic [DATA_W-1:0] hold_data_q, hold_data_d;
   logic [IDX_W-1:0]  hold_idx_q, hold_idx_d;
   logic [IDX_W-1:0]  last_idx_q, last_idx_d;

   logic              hold_valid;
   logic              any_en;
   logic              out_fire;
   logic              in_fire;
   logic [IDX_W-1:0]  next_idx;
   logic [IDX_W-1:0]  cand_idx [WIDTH];
   logic [WIDTH-1:0]  cand_en;

   assign hold_valid = (state_q == ST_FULL);
   assign any_en     = |bus.i_en;
   assign out_fire   = hold_valid & bus.i_ready[hold_idx_q];

   // Gated by reset so nothing is accepted while the dispatcher is held in reset.
   assign bus.o_ready = i_rst_n & (~hold_valid | out_fire) & any_en;
   assign in_fire     = bus.i_valid & bus.o_ready;

   // Candidate gi is the channel (gi+1) places after last_idx; the last candidate is last_idx itself.
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cand
         logic [CW-1:0] sum;
         assign sum          = {1'b0, last_idx_q} + CW'(gi + 1);
         assign cand_idx[gi] = (sum >= WIDTH_C) ? IDX_W'(sum - WIDTH_C) : sum[IDX_W-1:0];
         assign cand_en[gi]  = bus.i_en[cand_idx[gi]];
      end
   endgenerate

   // Lowest-offset enabled candidate wins; scanning downward lets it overwrite later ones.
   always_comb begin
      next_idx = last_idx_q;
      for (int k = WIDTH - 1; k >= 0; k--) begin
         if (cand_en[k]) begin
            next_idx = cand_idx[k];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      hold_data_d = hold_data_q;
      hold_idx_d  = hold_idx_q;
      last_idx_d  = last_idx_q;
      if (in_fire) begin
         state_d     = ST_FULL;
         hold_data_d = bus.i_data;
         hold_idx_d  = next_idx;
         last_idx_d  = next_idx;
      end else if (out_fire) begin
         state_d = ST_EMPTY;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= ST_EMPTY;
         hold_data_q <= '0;
         hold_idx_q  <= '0;
         last_idx_q  <= IDX_W'(WIDTH - 1);
      end else begin
         state_q     <= state_d;
         hold_data_q <= hold_data_d;
         hold_idx_q  <= hold_idx_d;
         last_idx_q  <= last_idx_d;
      end
   end

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_valid
         assign bus.o_valid[gi] = hold_valid & (hold_idx_q == IDX_W'(gi));
      end
   endgenerate

   // Data and index keep their last values when empty because the hold registers only load on accept.
   assign bus.o_data = hold_data_q;
   assign bus.o_idx  = hold_idx_q;
   assign bus.o_busy = hold_valid;
endmodule
